popcnt_arbiter: RTL and testbench

- Shares one bit_cntr_wrapper popcount datapath between NUM_REQ vector-stream requesters.
- Grants whole multi-word vectors atomically using round-robin arbitration and drives the counter's i_Vector/i_Valid/i_LastWordOfVector.
- Tags each vector with its requester ID in an in-order tag FIFO, then pairs each returned sum with its ID.
- Sits between the fingerprint fetch units and the Tanimoto score stage.

---
 rtl/popcnt_pkg.sv | 12 +
 rtl/popcnt_tag_fifo.sv | 57 +++++
 rtl/popcnt_arbiter.sv | 139 +++++++++++++
 tb/tb_popcnt_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcnt_pkg.sv
// Shared types and default sizing for the popcount arbiter slice.
package popcnt_pkg;
  localparam int unsigned NUM_REQ_DEF      = 4;
  localparam int unsigned MAX_INFLIGHT_DEF = 8;
  localparam int unsigned ID_WIDTH         = $clog2(NUM_REQ_DEF);
  localparam int unsigned FIFO_AW          = $clog2(MAX_INFLIGHT_DEF);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;
endpackage

// File: rtl/popcnt_tag_fifo.sv
// In-order requester-ID FIFO: one entry per vector started but not yet summed.
module popcnt_tag_fifo
  import popcnt_pkg::*;
#(
  parameter int unsigned WIDTH = ID_WIDTH,
  parameter int unsigned DEPTH = MAX_INFLIGHT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      count_n;

  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is then safe.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop) count_n = count + 1'b1;
    else if (!do_push && do_pop) count_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/popcnt_arbiter.sv
// Round-robin, vector-atomic sharing of one popcount datapath; returned sums
// are re-tagged with the owning requester via an in-order tag FIFO.
module popcnt_arbiter
  import popcnt_pkg::*;
#(
  parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
  parameter int unsigned VECTOR_WIDTH = 160,
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ*VECTOR_WIDTH-1:0]   i_ReqVector,
  input  logic [NUM_REQ-1:0]                i_ReqValid,
  input  logic [NUM_REQ-1:0]                i_ReqLast,
  output logic [NUM_REQ-1:0]                o_ReqReady,
  output logic [VECTOR_WIDTH-1:0]           o_CntVector,
  output logic                              o_CntValid,
  output logic                              o_CntLast,
  input  logic [OUTPUT_WIDTH-1:0]           i_CntSum,
  input  logic                              i_CntSumNew,
  output logic [OUTPUT_WIDTH-1:0]           o_Sum,
  output logic [$clog2(NUM_REQ)-1:0]        o_SumId,
  output logic                              o_SumValid,
  output logic                              o_Busy,
  output logic                              o_Error
);
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned AW  = $clog2(MAX_INFLIGHT);

  state_t                  state;
  logic [IDW-1:0]          owner;
  logic [IDW-1:0]          rr_ptr;
  logic [IDW:0]            pick;
  logic [IDW-1:0]          sel;
  logic                    accept;
  logic                    sel_last;
  logic [VECTOR_WIDTH-1:0] sel_word;
  logic                    push;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [AW:0]             fifo_count;
  logic [IDW-1:0]          fifo_head;

  // Returns {found, id} for the first valid requester at or after ptr.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IDW-1:0]     ptr);
    logic [IDW:0]         res;
    logic [NUM_REQ-1:0]   sh;
    int unsigned          idx;
    res = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      sh  = valid >> idx;
      if (!res[IDW] && sh[0]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    pick       = rr_pick(i_ReqValid, rr_ptr);
    o_ReqReady = '0;
    sel        = owner;
    if (state == ST_LOCKED) begin
      o_ReqReady = NUM_REQ'(1) << owner;
    end else begin
      sel = pick[IDW-1:0];
      if (pick[IDW] && !fifo_full) o_ReqReady = NUM_REQ'(1) << sel;
    end
    accept   = |(i_ReqValid & o_ReqReady);
    push     = accept && (state == ST_IDLE);
    sel_word = '0;
    sel_last = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (sel == IDW'(r)) begin
        sel_word = i_ReqVector[r*VECTOR_WIDTH +: VECTOR_WIDTH];
        sel_last = i_ReqLast[r];
      end
    end
  end

  popcnt_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sel),
    .pop       (i_CntSumNew),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      o_CntVector <= '0;
      o_CntValid  <= 1'b0;
      o_CntLast   <= 1'b0;
      o_Sum       <= '0;
      o_SumId     <= '0;
      o_SumValid  <= 1'b0;
      o_Busy      <= 1'b0;
      o_Error     <= 1'b0;
    end else begin
      o_CntValid <= accept;
      o_CntLast  <= accept && sel_last;
      if (accept) o_CntVector <= sel_word;

      if (accept) begin
        if (sel_last) begin
          state  <= ST_IDLE;
          rr_ptr <= next_id(sel);
        end else if (state == ST_IDLE) begin
          state <= ST_LOCKED;
          owner <= sel;
        end
      end

      o_SumValid <= i_CntSumNew && !fifo_empty;
      if (i_CntSumNew && !fifo_empty) begin
        o_Sum   <= i_CntSum;
        o_SumId <= fifo_head;
      end
      if (i_CntSumNew && fifo_empty) o_Error <= 1'b1;

      o_Busy <= (state == ST_LOCKED) || (fifo_count != '0);
    end
  end
endmodule

// File: tb/tb_popcnt_arbiter.sv
// Scoreboard bench for popcnt_arbiter with a behavioural popcount counter model.
module tb_popcnt_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned VW = 160;
  localparam int unsigned OW = 16;

  typedef struct packed {
    logic [VW-1:0] data;
    logic          last;
    logic [7:0]    gap;
  } word_t;

  typedef struct packed {
    logic [OW-1:0] sum;
    logic [1:0]    id;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*VW-1:0]  i_ReqVector = '0;
  logic [NR-1:0]     i_ReqValid = '0;
  logic [NR-1:0]     i_ReqLast = '0;
  logic [NR-1:0]     o_ReqReady;
  logic [VW-1:0]     o_CntVector;
  logic              o_CntValid;
  logic              o_CntLast;
  logic [OW-1:0]     i_CntSum = '0;
  logic              i_CntSumNew = 1'b0;
  logic [OW-1:0]     o_Sum;
  logic [1:0]        o_SumId;
  logic              o_SumValid;
  logic              o_Busy;
  logic              o_Error;

  popcnt_arbiter #(
    .NUM_REQ      (NR),
    .VECTOR_WIDTH (VW),
    .OUTPUT_WIDTH (OW),
    .MAX_INFLIGHT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ReqVector (i_ReqVector),
    .i_ReqValid  (i_ReqValid),
    .i_ReqLast   (i_ReqLast),
    .o_ReqReady  (o_ReqReady),
    .o_CntVector (o_CntVector),
    .o_CntValid  (o_CntValid),
    .o_CntLast   (o_CntLast),
    .i_CntSum    (i_CntSum),
    .i_CntSumNew (i_CntSumNew),
    .o_Sum       (o_Sum),
    .o_SumId     (o_SumId),
    .o_SumValid  (o_SumValid),
    .o_Busy      (o_Busy),
    .o_Error     (o_Error)
  );

  always #5 clk = ~clk;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  int unsigned   cyc = 0;
  word_t         rq [NR][$];
  word_t         cnt_exp [$];
  exp_t          exp_q [$];
  logic [OW-1:0] cnt_sum_q [$];
  int unsigned   log_id [$];
  int unsigned   log_cyc [$];
  logic [NR-1:0] accepted = '0;
  logic          exp_cv = 1'b0;
  int unsigned   acc = 0;
  int unsigned   sv_count = 0;
  bit            hold = 1'b0;
  int unsigned   credit = 0;
  int unsigned   inject = 0;
  int unsigned   sn_cyc = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  function automatic logic [VW-1:0] ones(input int unsigned n);
    logic [VW-1:0] one;
    one = 1;
    return (n >= VW) ? '1 : ((one << n) - 1'b1);
  endfunction

  task automatic push_word(input int unsigned r, input logic [VW-1:0] d, input logic l, input logic [7:0] g);
    word_t w;
    w.data = d;
    w.last = l;
    w.gap  = g;
    rq[r].push_back(w);
  endtask

  task automatic expect_sum(input logic [1:0] id, input int unsigned s);
    exp_t e;
    e.id  = id;
    e.sum = OW'(s);
    exp_q.push_back(e);
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0) || (cnt_sum_q.size() != 0);
    for (int r = 0; r < NR; r++) if (rq[r].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (pending() && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) chk("drain_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic wait_accept(input int unsigned id, input int unsigned from);
    int unsigned n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      for (int i = int'(from); i < log_id.size(); i++) if (log_id[i] == id) seen = 1'b1;
    end
    if (!seen) chk("accept_timeout", 0, 1);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Counter model, result scoreboard and requester drivers share one process
  // so their per-cycle ordering is deterministic.
  initial begin
    word_t ew;
    exp_t  e;
    word_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_cv || o_CntValid) chk("cnt_valid", VW'(o_CntValid), VW'(exp_cv));
      if (o_CntValid) begin
        if (cnt_exp.size() == 0) chk("cnt_unexpected", 1, 0);
        else begin
          ew = cnt_exp.pop_front();
          chk("cnt_vector", o_CntVector, ew.data);
          chk("cnt_last", VW'(o_CntLast), VW'(ew.last));
        end
        acc += $countones(o_CntVector);
        if (o_CntLast) begin
          cnt_sum_q.push_back(OW'(acc));
          acc = 0;
        end
      end
      if (o_SumValid) begin
        sv_count++;
        if (exp_q.size() == 0) chk("sum_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sum", VW'(o_Sum), VW'(e.sum));
          chk("sum_id", VW'(o_SumId), VW'(e.id));
        end
      end
      i_CntSumNew = 1'b0;
      if (inject > 0) begin
        i_CntSumNew = 1'b1;
        i_CntSum    = OW'($urandom());
        inject--;
      end else if (cnt_sum_q.size() != 0 && (!hold || credit > 0)) begin
        i_CntSumNew = 1'b1;
        i_CntSum    = cnt_sum_q.pop_front();
        if (hold) credit--;
        sn_cyc = cyc;
      end
      for (int r = 0; r < NR; r++)
        if (accepted[r] && rq[r].size() != 0) void'(rq[r].pop_front());
      for (int r = 0; r < NR; r++) begin
        i_ReqValid[r] = 1'b0;
        i_ReqLast[r]  = 1'b0;
        if (rq[r].size() != 0) begin
          w = rq[r][0];
          if (w.gap != 0) begin
            w.gap = w.gap - 1'b1;
            rq[r][0] = w;
          end else begin
            i_ReqValid[r] = 1'b1;
            i_ReqLast[r]  = w.last;
            i_ReqVector[r*VW +: VW] = w.data;
          end
        end
      end
      #1;
      accepted = i_ReqValid & o_ReqReady;
      exp_cv = 1'b0;
      if (rst) begin
        accepted = '0;
        cnt_exp.delete();
        cnt_sum_q.delete();
        acc = 0;
      end else if (accepted != '0) begin
        chk("single_grant", VW'($countones(accepted)), 1);
        for (int r = 0; r < NR; r++) begin
          if (accepted[r]) begin
            cnt_exp.push_back(rq[r][0]);
            log_id.push_back(r);
            log_cyc.push_back(cyc);
            exp_cv = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   s;
    int unsigned   sv0;
    logic [VW-1:0] pat;
    logic [VW-1:0] d4 [9];
    int unsigned   ids4 [9];

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready", VW'(o_ReqReady), 0);
    chk("rst_cnt_vector", o_CntVector, 0);
    chk("rst_cnt_valid", VW'(o_CntValid), 0);
    chk("rst_cnt_last", VW'(o_CntLast), 0);
    chk("rst_sum", VW'(o_Sum), 0);
    chk("rst_sum_id", VW'(o_SumId), 0);
    chk("rst_sum_valid", VW'(o_SumValid), 0);
    chk("rst_busy", VW'(o_Busy), 0);
    chk("rst_error", VW'(o_Error), 0);

    // Two-word vector from req0, 96 ones in the last word.
    pat = 160'hFFFFFFFF00000000FFFFFFFF00000000FFFFFFFF;
    push_word(0, '0, 1'b0, 8'd0);
    push_word(0, pat, 1'b1, 8'd0);
    expect_sum(2'd0, 96);
    drain(100);
    chk("t1_sumvalid_pulses", VW'(sv_count), 1);
    chk("t1_busy_idle", VW'(o_Busy), 0);

    // All four requesters at once from pointer 0.
    do_reset();
    s = log_id.size();
    push_word(0, '1, 1'b0, 8'd0);          push_word(0, ones(40), 1'b1, 8'd0);
    push_word(1, ones(100), 1'b0, 8'd0);   push_word(1, ones(100) << 60, 1'b1, 8'd0);
    push_word(2, '0, 1'b0, 8'd0);          push_word(2, '0, 1'b1, 8'd0);
    push_word(3, '1, 1'b0, 8'd0);          push_word(3, ones(120), 1'b1, 8'd0);
    expect_sum(2'd0, 200);
    expect_sum(2'd1, 200);
    expect_sum(2'd2, 0);
    expect_sum(2'd3, 280);
    drain(200);
    if (log_id.size() < s + 8) chk("t2_accept_count", VW'(log_id.size() - s), 8);
    else for (int i = 0; i < 8; i++) chk("t2_grant_order", VW'(log_id[s + i]), VW'(i / 2));

    // Req1 stalls three cycles while locked; req2 waits.
    s = log_id.size();
    push_word(1, ones(33), 1'b0, 8'd0);
    push_word(1, ones(7), 1'b1, 8'd3);
    push_word(2, ones(150), 1'b1, 8'd0);
    expect_sum(2'd1, 40);
    expect_sum(2'd2, 150);
    wait_accept(1, s);
    tick();
    chk("t3_ready_owner", VW'(o_ReqReady), VW'(4'b0010));
    tick();
    chk("t3_busy_locked", VW'(o_Busy), 1);
    chk("t3_req2_blocked", VW'(o_ReqReady[2]), 0);
    drain(200);
    if (log_id.size() < s + 3) chk("t3_accept_count", VW'(log_id.size() - s), 3);
    else begin
      chk("t3_order_a", VW'(log_id[s]), 1);
      chk("t3_order_b", VW'(log_id[s + 1]), 1);
      chk("t3_order_c", VW'(log_id[s + 2]), 2);
      chk("t3_lock_span", VW'(log_cyc[s + 1] - log_cyc[s]), 4);
      chk("t3_next_grant", VW'(log_cyc[s + 2] - log_cyc[s + 1]), 1);
    end

    // Fill the tag FIFO with sums withheld.
    hold = 1'b1;
    credit = 0;
    s = log_id.size();
    for (int i = 0; i < 9; i++) begin
      d4[i]   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      ids4[i] = (i % 2 == 0) ? 0 : 2;
      push_word(ids4[i], d4[i], 1'b1, 8'd0);
      expect_sum(2'(ids4[i]), $countones(d4[i]));
    end
    repeat (14) tick();
    chk("t4_accepted_at_full", VW'(log_id.size() - s), 8);
    chk("t4_ready_blocked", VW'(o_ReqReady), 0);
    credit = 1;
    repeat (4) tick();
    if (log_id.size() < s + 9) chk("t4_resume", VW'(log_id.size() - s), 9);
    else begin
      chk("t4_resume_id", VW'(log_id[s + 8]), 0);
      chk("t4_resume_cycle", VW'(log_cyc[s + 8] - sn_cyc), 1);
    end
    hold = 1'b0;
    drain(300);

    // Orphan sum with an empty tag FIFO.
    sv0 = sv_count;
    inject = 1;
    repeat (3) tick();
    chk("t5_error_set", VW'(o_Error), 1);
    chk("t5_no_sumvalid", VW'(sv_count), VW'(sv0));
    repeat (5) tick();
    chk("t5_error_sticky", VW'(o_Error), 1);

    // Reset in the middle of a req3 vector.
    s = log_id.size();
    push_word(3, ones(10), 1'b0, 8'd0);
    push_word(3, ones(20), 1'b0, 8'd5);
    push_word(3, ones(30), 1'b1, 8'd0);
    wait_accept(3, s);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rq[3].delete();
    chk("t6_ready", VW'(o_ReqReady), 0);
    chk("t6_cnt_valid", VW'(o_CntValid), 0);
    chk("t6_cnt_vector", o_CntVector, 0);
    chk("t6_busy", VW'(o_Busy), 0);
    chk("t6_error_cleared", VW'(o_Error), 0);
    chk("t6_sum_valid", VW'(o_SumValid), 0);
    s = log_id.size();
    push_word(3, ones(77), 1'b1, 8'd0);
    push_word(0, ones(5), 1'b1, 8'd0);
    expect_sum(2'd0, 5);
    expect_sum(2'd3, 77);
    drain(100);
    if (log_id.size() < s + 2) chk("t6_accept_count", VW'(log_id.size() - s), 2);
    else chk("t6_first_grant", VW'(log_id[s]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
